// File: rtl/targeting_pkg.sv
// -----------------------------------------------------------------------------
// targeting_pkg
//   Shared definitions for the proton cannon scheduler: FSM state encoding,
//   default timing/ammunition constants and a small constant helper.
// -----------------------------------------------------------------------------
package targeting_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CHARGE   = 2'd1,
        ST_FIRE     = 2'd2,
        ST_COOLDOWN = 2'd3
    } state_e;

    localparam int DEF_N_CH       = 4;
    localparam int DEF_CHARGE_CYC = 8;
    localparam int DEF_COOL_CYC   = 12;
    localparam int DEF_AMMO_W     = 4;
    localparam int DEF_MAX_AMMO   = 15;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin pick: the first set request bit at or
//   after ptr_i, wrapping around.
// Ports:
//   req_i  [N_CH]   request vector
//   ptr_i  [IDX_W]  highest-priority channel for this pick
//   gnt_o  [N_CH]   one-hot grant (all zero when no request)
//   idx_o  [IDX_W]  index of the granted channel
//   vld_o           a request was granted
// -----------------------------------------------------------------------------
module rr_arbiter
    import targeting_pkg::*;
#(
    parameter  int N_CH  = DEF_N_CH,
    localparam int IDX_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_CH-1:0]  gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             vld_o
);

    int               c;
    logic [IDX_W-1:0] cidx;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        c     = 0;
        cidx  = '0;
        for (int k = 0; k < N_CH; k++) begin
            // Explicit wrap so non-power-of-two channel counts work.
            c = int'(ptr_i) + k;
            if (c >= N_CH) c = c - N_CH;
            cidx = IDX_W'(c);
            if (!vld_o && req_i[cidx]) begin
                vld_o       = 1'b1;
                gnt_o[cidx] = 1'b1;
                idx_o       = cidx;
            end
        end
    end

endmodule

// File: rtl/proton_fire_scheduler.sv
// -----------------------------------------------------------------------------
// proton_fire_scheduler
//   Shares one proton cannon between N_CH targeting channels. Latches fire
//   requests, picks one round-robin, then runs CHARGE -> FIRE -> COOLDOWN,
//   enforcing the ammunition count and the master arm interlock.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   fire_req [N_CH]  per-channel one-cycle request strobes
//   arm              master arm; low inhibits dispatch and aborts CHARGE
//   reload           reload ammo to MAX_AMMO (IDLE only)
//   cannon_fire      one-cycle fire pulse
//   fire_ch          channel being serviced
//   grant    [N_CH]  one-hot on the serviced channel during FIRE
//   busy             any state other than IDLE
//   pending  [N_CH]  latched, unserviced requests
//   ammo     [AMMO_W] rounds remaining
//   empty            ammo == 0
// -----------------------------------------------------------------------------
module proton_fire_scheduler
    import targeting_pkg::*;
#(
    parameter  int N_CH       = DEF_N_CH,
    parameter  int CHARGE_CYC = DEF_CHARGE_CYC,
    parameter  int COOL_CYC   = DEF_COOL_CYC,
    parameter  int AMMO_W     = DEF_AMMO_W,
    parameter  int MAX_AMMO   = DEF_MAX_AMMO,
    localparam int IDX_W      = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   fire_req,
    input  logic              arm,
    input  logic              reload,
    output logic              cannon_fire,
    output logic [IDX_W-1:0]  fire_ch,
    output logic [N_CH-1:0]   grant,
    output logic              busy,
    output logic [N_CH-1:0]   pending,
    output logic [AMMO_W-1:0] ammo,
    output logic              empty
);

    localparam int TMR_MAX = max_int(CHARGE_CYC, COOL_CYC);
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    state_e             state_q, state_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [N_CH-1:0]    pending_q, pending_d;
    logic [AMMO_W-1:0]  ammo_q, ammo_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   fire_ch_q, fire_ch_d;

    logic [N_CH-1:0]    pend_in;
    logic [N_CH-1:0]    ch_oh;
    logic [N_CH-1:0]    arb_gnt;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_vld;

    // Includes this cycle's strobes so a request can be dispatched on arrival.
    assign pend_in = pending_q | fire_req;
    assign ch_oh   = N_CH'(1) << fire_ch_q;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req_i (pend_in),
        .ptr_i (rr_q),
        .gnt_o (arb_gnt),
        .idx_o (arb_idx),
        .vld_o (arb_vld)
    );

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        pending_d = pend_in;
        ammo_d    = ammo_q;
        rr_d      = rr_q;
        fire_ch_d = fire_ch_q;
        unique case (state_q)
            ST_IDLE: begin
                // Reload takes priority; a ready dispatch simply waits a cycle.
                if (reload) begin
                    ammo_d = AMMO_W'(MAX_AMMO);
                end else if (arm && !empty && arb_vld) begin
                    fire_ch_d = arb_idx;
                    pending_d = pend_in & ~arb_gnt;
                    timer_d   = TMR_W'(CHARGE_CYC - 1);
                    state_d   = ST_CHARGE;
                end
            end
            ST_CHARGE: begin
                // Disarm aborts the shot and hands the request back.
                if (!arm) begin
                    pending_d = pend_in | ch_oh;
                    state_d   = ST_IDLE;
                end else if (timer_q == '0) begin
                    state_d = ST_FIRE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_FIRE: begin
                if (ammo_q != '0) ammo_d = ammo_q - 1'b1;
                rr_d    = (fire_ch_q == IDX_W'(N_CH - 1)) ? '0 : fire_ch_q + 1'b1;
                timer_d = TMR_W'(COOL_CYC - 1);
                state_d = ST_COOLDOWN;
            end
            ST_COOLDOWN: begin
                if (timer_q == '0) state_d = ST_IDLE;
                else               timer_d = timer_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        // With no ammo, requests are refused rather than stored.
        if (empty) pending_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            pending_q <= '0;
            ammo_q    <= AMMO_W'(MAX_AMMO);
            rr_q      <= '0;
            fire_ch_q <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            ammo_q    <= ammo_d;
            rr_q      <= rr_d;
            fire_ch_q <= fire_ch_d;
        end
    end

    assign cannon_fire = (state_q == ST_FIRE);
    assign grant       = (state_q == ST_FIRE) ? ch_oh : '0;
    assign busy        = (state_q != ST_IDLE);
    assign fire_ch     = fire_ch_q;
    assign pending     = pending_q;
    assign ammo        = ammo_q;
    assign empty       = (ammo_q == '0);

endmodule

// File: tb/tb_proton_fire_scheduler.sv
module tb_proton_fire_scheduler;

    localparam int N  = 4;
    localparam int CH = 8;
    localparam int CL = 12;
    localparam int AW = 4;
    localparam int MA = 15;
    localparam int IW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  fire_req = '0;
    logic          arm = 1'b0;
    logic          reload = 1'b0;
    logic          cannon_fire;
    logic [IW-1:0] fire_ch;
    logic [N-1:0]  grant;
    logic          busy;
    logic [N-1:0]  pending;
    logic [AW-1:0] ammo;
    logic          empty;

    int checks = 0;
    int errors = 0;

    proton_fire_scheduler #(
        .N_CH(N), .CHARGE_CYC(CH), .COOL_CYC(CL), .AMMO_W(AW), .MAX_AMMO(MA)
    ) dut (
        .clk(clk), .rst_n(rst_n), .fire_req(fire_req), .arm(arm), .reload(reload),
        .cannon_fire(cannon_fire), .fire_ch(fire_ch), .grant(grant), .busy(busy),
        .pending(pending), .ammo(ammo), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model (timestamp based) ----------------
    // A shot dispatched at edge index t0 is charging while 0 <= now-t0 < CH,
    // fires at now-t0 == CH and is back in idle after now-t0 == CH+CL.
    logic         m_active;
    logic [N-1:0] m_pend, m_pin;
    int           m_ammo, m_rr, m_ch, m_cyc, m_t0, m_d, m_c;
    logic         m_found, m_was_empty;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0; m_pend = '0; m_ammo = MA; m_rr = 0; m_ch = 0;
            m_cyc = 0; m_t0 = 0;
        end else begin
            m_pin       = m_pend | fire_req;
            m_d         = m_cyc - m_t0;
            m_was_empty = (m_ammo == 0);
            if (!m_active) begin
                if (reload) begin
                    m_ammo = MA;
                end else if (arm && m_ammo != 0 && m_pin != 0) begin
                    m_found = 1'b0;
                    for (int k = 0; k < N; k++) begin
                        m_c = (m_rr + k) % N;
                        if (!m_found && ((m_pin >> m_c) & 1) != 0) begin
                            m_found = 1'b1;
                            m_ch    = m_c;
                        end
                    end
                    m_pin    = m_pin & ~(N'(1) << m_ch);
                    m_active = 1'b1;
                    m_t0     = m_cyc + 1;
                end
            end else if (m_d < CH) begin
                if (!arm) begin
                    m_active = 1'b0;
                    m_pin    = m_pin | (N'(1) << m_ch);
                end
            end else if (m_d == CH) begin
                if (m_ammo > 0) m_ammo = m_ammo - 1;
                m_rr = (m_ch + 1) % N;
            end else if (m_d == CH + CL) begin
                m_active = 1'b0;
            end
            m_pend = m_was_empty ? '0 : m_pin;
            m_cyc  = m_cyc + 1;
        end
    end

    logic         e_fire;
    logic [N-1:0] e_grant;
    int           fires = 0;
    int           fires_ch1 = 0;

    always @(negedge clk) begin
        e_fire  = m_active && (m_cyc - m_t0 == CH);
        e_grant = e_fire ? (N'(1) << m_ch) : '0;
        chk("cyc_cannon_fire", 32'(cannon_fire), 32'(e_fire));
        chk("cyc_grant",       32'(grant),       32'(e_grant));
        chk("cyc_fire_ch",     32'(fire_ch),     m_ch);
        chk("cyc_busy",        32'(busy),        32'(m_active));
        chk("cyc_pending",     32'(pending),     32'(m_pend));
        chk("cyc_ammo",        32'(ammo),        m_ammo);
        chk("cyc_empty",       32'(empty),       32'(m_ammo == 0));
        if (cannon_fire) begin
            fires++;
            if (fire_ch == IW'(1)) fires_ch1++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [N-1:0] r, input logic a, input logic rl);
        fire_req = r; arm = a; reload = rl;
        @(posedge clk); #1;
        fire_req = '0; reload = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive('0, arm, 1'b0);
    endtask

    task automatic wait_fire(input int bound, output int n);
        n = 0;
        while (!cannon_fire && n < bound) begin
            drive('0, arm, 1'b0);
            n++;
        end
        chk("wait_fire_timeout", 32'(cannon_fire), 32'd1);
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            drive('0, arm, 1'b0);
            n++;
        end
        chk("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; fire_req = '0; arm = 1'b0; reload = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cannon"},  32'(cannon_fire), 32'd0);
        chk({tag, "_grant"},   32'(grant),       32'd0);
        chk({tag, "_fire_ch"}, 32'(fire_ch),     32'd0);
        chk({tag, "_busy"},    32'(busy),        32'd0);
        chk({tag, "_pending"}, 32'(pending),     32'd0);
        chk({tag, "_ammo"},    32'(ammo),        32'd15);
        chk({tag, "_empty"},   32'(empty),       32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired time=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, f0, c0;
        logic [N-1:0] r;
        int exp_ch [3];
        exp_ch = '{0, 1, 3};

        // 1: single request latency and bookkeeping
        do_reset();
        chk_reset_vals("rst");
        drive(4'b0001, 1'b1, 1'b0);
        wait_fire(40, n);
        chk("t1_latency", n + 1, 32'd9);
        chk("t1_fire_ch", 32'(fire_ch), 32'd0);
        chk("t1_grant",   32'(grant),   32'b0001);
        drive('0, 1'b1, 1'b0);
        chk("t1_ammo",    32'(ammo),    32'd14);

        // 2: contention, round-robin order and spacing
        do_reset();
        drive(4'b1011, 1'b1, 1'b0);
        wait_fire(40, n);
        chk("t2_ch_0", 32'(fire_ch), exp_ch[0]);
        for (int s = 1; s < 3; s++) begin
            drive('0, 1'b1, 1'b0);
            wait_fire(60, n);
            chk("t2_gap", n + 1, 32'd22);
            chk("t2_ch",  32'(fire_ch), exp_ch[s]);
        end
        wait_idle(40);
        chk("t2_pending", 32'(pending), 32'd0);
        chk("t2_ammo",    32'(ammo),    32'd12);

        // 3: abort by disarm during CHARGE, then re-arm
        do_reset();
        f0 = fires;
        drive(4'b0100, 1'b1, 1'b0);
        idle(3);
        drive('0, 1'b0, 1'b0);
        idle(15);
        chk("t3_no_fire", fires - f0, 32'd0);
        chk("t3_pending", 32'(pending), 32'b0100);
        chk("t3_ammo",    32'(ammo),    32'd15);
        chk("t3_busy",    32'(busy),    32'd0);
        drive('0, 1'b1, 1'b0);
        wait_fire(40, n);
        chk("t3_refire_ch", 32'(fire_ch), 32'd2);

        // 4: ammo exhaustion and reload
        do_reset();
        arm = 1'b1;
        for (int s = 0; s < 15; s++) begin
            drive(4'b0001, 1'b1, 1'b0);
            wait_fire(40, n);
        end
        wait_idle(40);
        chk("t4_empty", 32'(empty), 32'd1);
        chk("t4_ammo",  32'(ammo),  32'd0);
        f0 = fires;
        drive(4'b1111, 1'b1, 1'b0);
        idle(15);
        chk("t4_no_fire", fires - f0, 32'd0);
        chk("t4_pending", 32'(pending), 32'd0);
        drive('0, 1'b1, 1'b1);
        chk("t4_reload", 32'(ammo),  32'd15);
        chk("t4_full",   32'(empty), 32'd0);

        // 5: merged re-requests during own CHARGE
        do_reset();
        c0 = fires_ch1;
        drive(4'b0010, 1'b1, 1'b0);
        drive(4'b0010, 1'b1, 1'b0);
        drive('0,      1'b1, 1'b0);
        drive(4'b0010, 1'b1, 1'b0);
        drive('0,      1'b1, 1'b0);
        drive(4'b0010, 1'b1, 1'b0);
        idle(80);
        chk("t5_ch1_shots", fires_ch1 - c0, 32'd2);
        chk("t5_pending",   32'(pending),   32'd0);

        // 6: asynchronous reset in COOLDOWN and in CHARGE
        do_reset();
        drive(4'b0001, 1'b1, 1'b0);
        wait_fire(40, n);
        idle(3);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("t6_cool");
        do_reset();
        drive(4'b0100, 1'b1, 1'b0);
        idle(2);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("t6_chg");
        do_reset();
        arm = 1'b1;
        f0 = fires;
        idle(20);
        chk("t6_no_stray", fires - f0, 32'd0);

        // Randomized traffic against the model
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            drive(r, ($urandom_range(0, 19) != 0), ($urandom_range(0, 29) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
